// File: rtl/hub75_bcm_scan_ctrl.sv
// hub75_bcm_scan_ctrl
//
// Scan scheduler for a HUB75 LED matrix panel. It walks scan rows and
// binary-coded-modulation (BCM) bit planes. For each pixel it fetches one
// 6-bit word from a framebuffer. For every row/plane it sequences the shift
// clock, blanking, the row address, the latch and a weighted output-enable
// window.
//
// Optional feature macro: BRIGHTNESS_EN
//   Adds input brightness[3:0]. Inside each SHOW window, OE is driven low only
//   for the first floor((brightness+1)*window/16) ticks. The window length
//   stays unchanged.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   enable              run scanning; sampled in IDLE before each row/plane
//   brightness[3:0]     (BRIGHTNESS_EN only) global dimming, sampled at SHOW entry
//   rd_req              pixel fetch request
//   rd_row/col/plane    address of the requested pixel bit
//   rd_valid, rd_data   fetch response {B2,G2,R2,B1,G1,R1}
//   H75_R1..H75_B2      panel colour data pins
//   H75_A..H75_E        row address bits 0..4
//   H75_Clk, H75_Lat    shift clock and latch
//   H75_OE              output enable, active low
//   frame_done          one-clk pulse after the last plane of the last row
//   dbg_state           current FSM state (encoding of state_t)
//
// Fetch handshake: rd_req is high exactly while the FSM is in FETCH. During
// that time rd_row/rd_col/rd_plane are held stable. A word transfers on the
// clk edge where rd_req and rd_valid are both high. rd_valid is ignored while
// rd_req is low.

module hub75_bcm_scan_ctrl #(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int BPC     = 4,
    parameter int CLK_DIV = 27,
    parameter int BASE_ON = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
`ifdef BRIGHTNESS_EN
    input  logic [3:0]                             brightness,
`endif
    output logic                                   rd_req,
    output logic [4:0]                             rd_row,
    output logic [$clog2(COLS)-1:0]                rd_col,
    output logic [((BPC > 1) ? $clog2(BPC) : 1)-1:0] rd_plane,
    input  logic                                   rd_valid,
    input  logic [5:0]                             rd_data,
    output logic                                   H75_R1,
    output logic                                   H75_G1,
    output logic                                   H75_B1,
    output logic                                   H75_R2,
    output logic                                   H75_G2,
    output logic                                   H75_B2,
    output logic                                   H75_A,
    output logic                                   H75_B,
    output logic                                   H75_C,
    output logic                                   H75_D,
    output logic                                   H75_E,
    output logic                                   H75_Clk,
    output logic                                   H75_Lat,
    output logic                                   H75_OE,
    output logic                                   frame_done,
    output logic [2:0]                             dbg_state
);

    localparam int CW     = $clog2(COLS);
    localparam int PW     = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Wide enough to hold the longest window, BASE_ON << (BPC-1), without wrap.
    localparam int SHOW_W = $clog2(BASE_ON << (BPC - 1)) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_CLK_HI   = 3'd2,
        S_CLK_LO   = 3'd3,
        S_BLANK    = 3'd4,
        S_LATCH_HI = 3'd5,
        S_LATCH_LO = 3'd6,
        S_SHOW     = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_cnt;
    logic              tick;
    logic [4:0]        row_q;
    logic [CW-1:0]     col_q;
    logic [PW-1:0]     plane_q;
    logic [SHOW_W-1:0] show_cnt;
    logic [SHOW_W-1:0] show_off;   // OE goes high once show_cnt drops to this
    logic [SHOW_W-1:0] win;
    logic [SHOW_W-1:0] on_ticks;
    logic [5:0]        data_q;
    logic [4:0]        addr_q;
    logic              clk_q, lat_q, oe_q, fd_q;
    logic              last_col;

    // Free-running tick prescaler. All pin timing is counted in ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick     = (div_cnt == DW'(CLK_DIV - 1));
    assign last_col = (col_q == CW'(COLS - 1));
    assign win      = SHOW_W'(BASE_ON) << plane_q;

`ifdef BRIGHTNESS_EN
    localparam int PRW = SHOW_W + 4;
    logic [PRW-1:0] on_prod;

    // (brightness+1) * window fits in SHOW_W+4 bits; >>4 is the /16.
    assign on_prod  = (PRW'(brightness) + PRW'(1)) * PRW'(win);
    assign on_ticks = SHOW_W'(on_prod >> 4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            show_off <= '0;
        end else if (state_q == S_LATCH_LO && tick) begin
            show_off <= win - on_ticks;
        end
    end
`else
    assign on_ticks = win;
    assign show_off = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Every step is tick-gated except the fetch wait.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (tick && enable) state_d = S_FETCH;
            S_FETCH:    if (rd_valid) state_d = S_CLK_HI;
            S_CLK_HI:   if (tick) state_d = S_CLK_LO;
            S_CLK_LO:   if (tick) state_d = last_col ? S_BLANK : S_FETCH;
            S_BLANK:    if (tick) state_d = S_LATCH_HI;
            S_LATCH_HI: if (tick) state_d = S_LATCH_LO;
            S_LATCH_LO: if (tick) state_d = S_SHOW;
            S_SHOW:     if (tick && show_cnt <= SHOW_W'(1)) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath and registered pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            plane_q  <= '0;
            show_cnt <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            clk_q    <= 1'b0;
            lat_q    <= 1'b0;
            oe_q     <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (rd_valid) data_q <= rd_data;
                end
                S_CLK_HI: begin
                    if (tick) clk_q <= 1'b1;
                end
                S_CLK_LO: begin
                    if (tick) begin
                        clk_q <= 1'b0;
                        col_q <= last_col ? '0 : col_q + CW'(1);
                    end
                end
                S_BLANK: begin
                    // The address moves while the panel is dark and before the latch.
                    if (tick) begin
                        oe_q   <= 1'b1;
                        addr_q <= row_q;
                    end
                end
                S_LATCH_HI: begin
                    if (tick) lat_q <= 1'b1;
                end
                S_LATCH_LO: begin
                    if (tick) begin
                        lat_q    <= 1'b0;
                        show_cnt <= win;
                        oe_q     <= (on_ticks == '0);
                    end
                end
                S_SHOW: begin
                    if (tick) begin
                        if (show_cnt > SHOW_W'(1)) begin
                            show_cnt <= show_cnt - SHOW_W'(1);
                            oe_q     <= !((show_cnt - SHOW_W'(1)) > show_off);
                        end else begin
                            show_cnt <= '0;
                            oe_q     <= 1'b1;
                            if (plane_q == PW'(BPC - 1)) begin
                                plane_q <= '0;
                                if (row_q == 5'(ROWS - 1)) begin
                                    row_q <= '0;
                                    fd_q  <= 1'b1;
                                end else begin
                                    row_q <= row_q + 5'd1;
                                end
                            end else begin
                                plane_q <= plane_q + PW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_req   = (state_q == S_FETCH);
    assign rd_row   = row_q;
    assign rd_col   = col_q;
    assign rd_plane = plane_q;

    assign {H75_B2, H75_G2, H75_R2, H75_B1, H75_G1, H75_R1} = data_q;
    assign {H75_E, H75_D, H75_C, H75_B, H75_A}             = addr_q;

    assign H75_Clk    = clk_q;
    assign H75_Lat    = lat_q;
    assign H75_OE     = oe_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hub75_bcm_scan_ctrl.sv
// Testbench for hub75_bcm_scan_ctrl with COLS=4, ROWS=2, BPC=2, CLK_DIV=2,
// BASE_ON=3. Each record describes one row/plane window: the data word, the
// expected fetch address, an optional stall and an optional enable drop. It
// also holds the expected latch address, OE-low time, window length and
// frame_done. Reset, enable-halt and brightness cases are written out by hand.

module tb_hub75_bcm_scan_ctrl;

    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int BPC     = 2;
    localparam int CLK_DIV = 2;
    localparam int BASE_ON = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SHOW  = 3'd7;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rd_valid = 1'b0;
    logic [5:0] rd_data = 6'd0;
`ifdef BRIGHTNESS_EN
    logic [3:0] brightness = 4'd15;
`endif

    logic       rd_req;
    logic [4:0] rd_row;
    logic [1:0] rd_col;
    logic [0:0] rd_plane;
    logic       H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2;
    logic       H75_A, H75_B, H75_C, H75_D, H75_E;
    logic       H75_Clk, H75_Lat, H75_OE, frame_done;
    logic [2:0] dbg_state;
    logic [5:0] pins;
    logic [4:0] addr;

    always #5 clk = ~clk;

    hub75_bcm_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
`ifdef BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .rd_req(rd_req),
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_plane(rd_plane),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .H75_R1(H75_R1), .H75_G1(H75_G1), .H75_B1(H75_B1),
        .H75_R2(H75_R2), .H75_G2(H75_G2), .H75_B2(H75_B2),
        .H75_A(H75_A), .H75_B(H75_B), .H75_C(H75_C), .H75_D(H75_D), .H75_E(H75_E),
        .H75_Clk(H75_Clk),
        .H75_Lat(H75_Lat),
        .H75_OE(H75_OE),
        .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    assign pins = {H75_B2, H75_G2, H75_R2, H75_B1, H75_G1, H75_R1};
    assign addr = {H75_E, H75_D, H75_C, H75_B, H75_A};

    // ---------------- vector records ----------------
    typedef struct {
        logic [5:0] data;
        logic [4:0] row;
        logic [0:0] plane;
        int         stall_col;
        int         stall_len;
        int         drop_en_col;
        int         on_clks;
        int         win_clks;
        logic       fd;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] data, input logic [4:0] row,
                                input logic [0:0] plane, input int stall_col,
                                input int stall_len, input int drop_en_col,
                                input int on_clks, input int win_clks, input logic fd);
        vec_t v;
        v.data = data; v.row = row; v.plane = plane;
        v.stall_col = stall_col; v.stall_len = stall_len; v.drop_en_col = drop_en_col;
        v.on_clks = on_clks; v.win_clks = win_clks; v.fd = fd;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Serve every column fetch of one row/plane and check each shift clock edge.
    task automatic shift_row(input vec_t v);
        int k;
        for (int c = 0; c < COLS; c++) begin
            k = 0;
            while (rd_req !== 1'b1 && k < 300) begin @(negedge clk); k++; end
            chk("rd_req_seen", rd_req, 1);
            chk("rd_row", rd_row, v.row);
            chk("rd_col", rd_col, c);
            chk("rd_plane", rd_plane, v.plane);
            chk("oe_in_fetch", H75_OE, 1);
            if (c == v.drop_en_col) enable = 1'b0;
            if (c == v.stall_col) begin
                for (int i = 0; i < v.stall_len; i++) begin
                    @(negedge clk);
                    chk("stall_rd_req", rd_req, 1);
                    chk("stall_rd_col", rd_col, c);
                    chk("stall_clk", H75_Clk, 0);
                    chk("stall_oe", H75_OE, 1);
                    chk("stall_state", dbg_state, ST_FETCH);
                end
            end
            rd_valid = 1'b1;
            rd_data  = v.data;
            @(negedge clk);
            chk("rd_req_drop", rd_req, 0);
            // A stray valid outside FETCH must not reach the data pins.
            rd_data = ~v.data;
            @(negedge clk);
            rd_valid = 1'b0;
            rd_data  = 6'd0;
            k = 0;
            while (H75_Clk !== 1'b1 && k < 300) begin @(negedge clk); k++; end
            chk("shift_clk_rise", H75_Clk, 1);
            chk("data_at_clk", pins, v.data);
        end
    endtask

    // Check latch pulse, then measure the SHOW window and OE-low time.
    task automatic latch_show(input vec_t v);
        int k, n, on;
        k = 0;
        while (H75_Lat !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk("lat_rise", H75_Lat, 1);
        n = 0;
        while (H75_Lat === 1'b1 && n < 50) begin
            chk("oe_at_latch", H75_OE, 1);
            chk("addr_at_latch", addr, v.row);
            @(negedge clk);
            n++;
        end
        chk("lat_width", n, 2);
        n  = 0;
        on = 0;
        while (dbg_state === ST_SHOW && n < 500) begin
            if (H75_OE === 1'b0) on++;
            @(negedge clk);
            n++;
        end
        chk("show_window", n, v.win_clks);
        chk("oe_low_clks", on, v.on_clks);
        chk("oe_after_show", H75_OE, 1);
        chk("frame_done", frame_done, v.fd);
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_oe"}, H75_OE, 1);
        chk({tag, "_clk"}, H75_Clk, 0);
        chk({tag, "_lat"}, H75_Lat, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_pins"}, pins, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t tbl[5];
    vec_t hv;

    initial begin
        int k, seen_req, seen_oe_low, seen_busy;

        // data, row, plane, stall_col, stall_len, drop_en_col, on_clks, win_clks, fd
        tbl[0] = mk(6'b010101, 5'd0, 1'b0, -1,  0, -1,  6,  6, 1'b0);
        tbl[1] = mk(6'b101010, 5'd0, 1'b1,  2, 10, -1, 12, 12, 1'b0);
        tbl[2] = mk(6'b111000, 5'd1, 1'b0, -1,  0, -1,  6,  6, 1'b0);
        tbl[3] = mk(6'b000111, 5'd1, 1'b1, -1,  0, -1, 12, 12, 1'b1);
        tbl[4] = mk(6'b110011, 5'd0, 1'b0, -1,  0, -1,  6,  6, 1'b0);

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        chk("por_rd_row", rd_row, 0);
        chk("por_rd_col", rd_col, 0);
        chk("por_rd_plane", rd_plane, 0);
        rst    = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 5; i++) begin
            shift_row(tbl[i]);
            latch_show(tbl[i]);
        end

        // enable falls mid-row: the row/plane completes, then the block halts
        hv = mk(6'b001100, 5'd0, 1'b1, -1, 0, 1, 12, 12, 1'b0);
        shift_row(hv);
        latch_show(hv);
        seen_req = 0; seen_oe_low = 0; seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen_req = 1;
            if (H75_OE !== 1'b1) seen_oe_low = 1;
            if (dbg_state !== ST_IDLE) seen_busy = 1;
        end
        chk("halt_no_req", seen_req, 0);
        chk("halt_oe_high", seen_oe_low, 0);
        chk("halt_idle", seen_busy, 0);
        enable = 1'b1;

        // Reset asserted between clock edges while row 1 is being shown
        hv = mk(6'b100001, 5'd1, 1'b0, -1, 0, -1, 6, 6, 1'b0);
        shift_row(hv);
        k = 0;
        while (H75_OE !== 1'b0 && k < 300) begin @(negedge clk); k++; end
        chk("oe_low_before_reset", H75_OE, 0);
        chk("addr_before_reset", addr, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Scan restarts at row 0, plane 0
        hv = mk(6'b011110, 5'd0, 1'b0, -1, 0, -1, 6, 6, 1'b0);
        shift_row(hv);
        latch_show(hv);

`ifdef BRIGHTNESS_EN
        // brightness 7, plane 1: floor(8*6/16) = 3 ticks low in a 6-tick window
        brightness = 4'd7;
        hv = mk(6'b010011, 5'd0, 1'b1, -1, 0, -1, 6, 12, 1'b0);
        shift_row(hv);
        latch_show(hv);
        // brightness 0, plane 0: floor(1*3/16) = 0, so OE stays high
        brightness = 4'd0;
        hv = mk(6'b101100, 5'd1, 1'b0, -1, 0, -1, 0, 6, 1'b0);
        shift_row(hv);
        latch_show(hv);
        brightness = 4'd15;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
